value_text_driver: RTL and testbench
====================================

// Module: value_text_driver
// PURPOSE
//  Drives the 16x32 digit font decoder so it renders a binary sensor reading
//  (e.g. greenhouse temperature or humidity) as a row of decimal digits.
//  - Accepts a binary value over a valid/ready handshake.
//  - Converts it to BCD with a sequential double-dabble FSM.
//  - Commits the digits at a frame boundary so the display never tears.
//  - Per pixel, supplies character_code, char_start_x and char_start_y to the
//    font decoder, and registers its on_char result into pixel_on.
// PARAMETERS
//  DIGITS    4      number of decimal digit tiles, 1..5
//  VALUE_W   14     width of the binary input value
//  ORIGIN_X  64     x of the leftmost tile start (10-bit)
//  ORIGIN_Y  32     y of the tile row start (10-bit)
//  CHAR_W    16     tile width in pixels; must be a power of two
//  CHAR_H    32     tile height in pixels
// PORTS
//  clk             in   1        pixel clock
//  rst_n           in   1        asynchronous reset, active low
//  value_valid     in   1        value holds a new reading
//  value           in   VALUE_W  unsigned binary reading
//  value_ready     out  1        block can accept a value (IDLE only)
//  frame_start     in   1        1-cycle pulse at the start of vertical blanking
//  x, y            in   10       current scan pixel coordinates
//  video_on        in   1        scan position is in the visible area
//  character_code  out  8        digit 0..9 sent to the font decoder
//  char_start_x    out  10       tile x start sent to the font decoder
//  char_start_y    out  10       tile y start sent to the font decoder
//  on_char         in   1        font decoder result for (x,y), combinational
//  pixel_on        out  1        registered: draw foreground at the previous (x,y)
//  busy            out  1        conversion or commit is pending
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0):
//  - FSM=IDLE; shadow and display digits all 0; pixel_on=0; busy=0; value_ready=1.
//  FSM states:
//  - IDLE: value_ready=1. On value_valid&&value_ready, latch value, clear the BCD
//    shift register, set cnt=VALUE_W, go to CONVERT.
//  - CONVERT: each cycle, add 3 to every BCD nibble >=5, then shift left
//    {bcd,bin} by 1 and decrement cnt. After VALUE_W shifts, go to HOLD.
//    Latency is exactly VALUE_W cycles.
//  - Overflow: if value > 10^DIGITS-1, the shadow digits are all 9 (saturate).
//  - HOLD: wait for frame_start, then copy shadow to display digits in that same
//    cycle and go to IDLE.
//    If frame_start arrives in CONVERT, it is ignored; the commit waits for the
//    next frame_start.
//  - busy=1 in CONVERT and HOLD. value_ready=0 in CONVERT and HOLD, so new
//    values wait and are never dropped or merged.
//  - rst_n asserted mid-conversion: abort; the display shows 0s.
//  Tile selection (combinational from x, y):
//  - dx = x-ORIGIN_X; idx = dx>>log2(CHAR_W).
//  - in_row = (x>=ORIGIN_X) && (idx<DIGITS) && (y>=ORIGIN_Y) && (y<ORIGIN_Y+CHAR_H).
//  - char_start_x = ORIGIN_X + idx*CHAR_W; char_start_y = ORIGIN_Y.
//  - character_code = {4'b0, display digit idx}; idx 0 is the most significant digit.
//  - Outside the row: character_code=0, char_start_x=ORIGIN_X, char_start_y=ORIGIN_Y.
//  - Arithmetic is 10 bits, unsigned. x<ORIGIN_X must not wrap into a valid idx.
//  Pixel output:
//  - pixel_on <= video_on && in_row && on_char && !blank(idx).
//  - Latency is 1 clk from (x,y) to pixel_on.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//  - Display digits above the most significant nonzero digit are blanked
//    (blank(idx)=1), so pixel_on=0 over their tiles.
//  - The least significant digit is never blanked (value 0 shows "0").
//  - Blank flags are computed at commit time.
//  LEADING_ZERO_BLANK_EN undefined:
//  - blank(idx)=0 always; all DIGITS digits show, including leading zeros
//    (e.g. "0042").
// TESTING
//  1. Reset mid-CONVERT -> busy=0, value_ready=1, pixel_on=0, all display digits 0.
//  2. value=1234 accepted; frame_start pulse 20 clk later -> busy high for exactly
//     14 clk of CONVERT, then HOLD until the pulse; digits={1,2,3,4} on the
//     following frame.
//  3. value=12000 (DIGITS=4) -> display saturates to {9,9,9,9}.
//  4. value=42 with macro defined -> tiles 0 and 1 give pixel_on=0; tiles 2,3 show
//     4,2. Macro undefined -> "0042". value=0 with macro -> only tile 3 shows "0".
//  5. Sweep x=60..130 at y=40 -> character_code/char_start_x step at x=64,80,96,112;
//     pixel_on=0 for x<64 and x>=128; pixel_on tracks on_char with 1-clk delay.
//  6. Second value_valid while busy -> value_ready=0, no capture; it is accepted
//     the cycle after the commit (IDLE).

Source files
------------

// File: rtl/value_text_driver.sv
// Renders a binary reading as DIGITS decimal tiles for a 16x32 font decoder; double-dabble BCD conversion, frame-synchronous commit.
// Latency: conversion takes VALUE_W cycles, then the commit waits for frame_start; pixel_on trails (x,y) by 1 clk.
// Backpressure: value_ready is high only in IDLE, so a new reading waits until the current one is committed. Optional: LEADING_ZERO_BLANK_EN.
module value_text_driver #(
    parameter int DIGITS   = 4,
    parameter int VALUE_W  = 14,
    parameter int ORIGIN_X = 64,
    parameter int ORIGIN_Y = 32,
    parameter int CHAR_W   = 16,
    parameter int CHAR_H   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               value_valid,
    input  logic [VALUE_W-1:0] value,
    output logic               value_ready,
    input  logic               frame_start,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               video_on,
    output logic [7:0]         character_code,
    output logic [9:0]         char_start_x,
    output logic [9:0]         char_start_y,
    input  logic               on_char,
    output logic               pixel_on,
    output logic               busy
);
    localparam int SH        = $clog2(CHAR_W);
    // Enough BCD nibbles to hold 2^VALUE_W-1, and never fewer than DIGITS.
    localparam int BCD_RAW   = (VALUE_W * 302) / 1000 + 1;
    localparam int BCD_N     = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
    localparam int BW        = 4 * BCD_N;
    localparam int CW        = $clog2(VALUE_W + 1);
    localparam logic [9:0]  OX    = 10'(ORIGIN_X);
    localparam logic [9:0]  OY    = 10'(ORIGIN_Y);
    localparam logic [9:0]  NDIG  = 10'(DIGITS);
    localparam logic [10:0] YEND  = 11'(ORIGIN_Y + CHAR_H);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_HOLD} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [BW-1:0]      bcd_q, bcd_adj, bcd_d;
    logic [3:0]         shadow_q [DIGITS];
    logic [3:0]         shadow_d [DIGITS];
    logic [3:0]         disp_q   [DIGITS];
    logic               busy_q, ready_q, pixel_q;
    logic               over;
    logic [DIGITS-1:0]  blank_vec;

    // One double-dabble step: adjust nibbles >=5, then shift {bcd,bin} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[BW-2:0], bin_q[VALUE_W-1]};
        bin_d = {bin_q[VALUE_W-2:0], 1'b0};
    end

    // Shadow digits from the final step; any nonzero nibble above DIGITS saturates to all 9s.
    always_comb begin
        over = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++) begin
            over = over | (bcd_d[4*i +: 4] != 4'd0);
        end
        for (int k = 0; k < DIGITS; k++) begin
            shadow_d[k] = over ? 4'd9 : bcd_d[4*(DIGITS-1-k) +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              seen;

    // Blank every digit left of the first nonzero one; the last digit always shows.
    always_comb begin
        seen    = 1'b0;
        blank_d = '0;
        for (int k = 0; k < DIGITS - 1; k++) begin
            seen       = seen | (shadow_q[k] != 4'd0);
            blank_d[k] = !seen;
        end
    end

    // Blank flags are captured together with the display digits at commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (state_q == S_HOLD && frame_start) begin
            blank_q <= blank_d;
        end
    end

    assign blank_vec = blank_q;
`else
    assign blank_vec = '0;
`endif

    // Control FSM: accept, convert for VALUE_W cycles, hold until frame boundary, commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                shadow_q[k] <= 4'd0;
                disp_q[k]   <= 4'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (value_valid && ready_q) begin
                        bin_q   <= value;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(VALUE_W);
                        state_q <= S_CONVERT;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                S_CONVERT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        shadow_q <= shadow_d;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (frame_start) begin
                        disp_q  <= shadow_q;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    logic [9:0] dx, idx;
    logic       in_row, blank_sel;

    // Tile lookup: the x>=ORIGIN_X guard keeps a wrapped dx from selecting a tile.
    always_comb begin
        dx             = x - OX;
        idx            = dx >> SH;
        in_row         = (x >= OX) && (idx < NDIG) && (y >= OY) && ({1'b0, y} < YEND);
        character_code = 8'd0;
        char_start_x   = OX;
        blank_sel      = 1'b0;
        if (in_row) begin
            char_start_x = OX + (idx << SH);
            for (int k = 0; k < DIGITS; k++) begin
                if (idx == 10'(k)) begin
                    character_code = {4'b0, disp_q[k]};
                    blank_sel      = blank_vec[k];
                end
            end
        end
    end

    assign char_start_y = OY;

    // Register the font decoder result for the current pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= 1'b0;
        end else begin
            pixel_q <= video_on && in_row && on_char && !blank_sel;
        end
    end

    assign pixel_on    = pixel_q;
    assign busy        = busy_q;
    assign value_ready = ready_q;

endmodule

// File: tb/tb_value_text_driver.sv
module tb_value_text_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        value_valid = 1'b0;
    logic [13:0] value = '0;
    logic        frame_start = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        video_on = 1'b0;
    logic        on_char = 1'b0;
    logic        value_ready, pixel_on, busy;
    logic [7:0]  character_code;
    logic [9:0]  char_start_x, char_start_y;

    int n_err = 0;
    int n_chk = 0;

    value_text_driver dut (
        .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value(value),
        .value_ready(value_ready), .frame_start(frame_start), .x(x), .y(y),
        .video_on(video_on), .character_code(character_code),
        .char_start_x(char_start_x), .char_start_y(char_start_y),
        .on_char(on_char), .pixel_on(pixel_on), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int g;
        g = 0;
        value       = 14'(v);
        value_valid = 1'b1;
        while (!value_ready && g < 50) begin
            tick(1);
            g++;
        end
        check("send_timeout", 32'(g < 50), 1);
        tick(1);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 40) begin
            tick(1);
            g++;
        end
        check("idle_timeout", 32'(g < 40), 1);
    endtask

    // Checks each tile's code and its registered pixel with on_char forced high.
    task automatic check_tiles(input string tag, input int d0, input int d1, input int d2, input int d3,
                               input int p0, input int p1, input int p2, input int p3);
        int d[4];
        int p[4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int k = 0; k < 4; k++) begin
            x        = 10'(64 + 16 * k + 2);
            y        = 10'd40;
            video_on = 1'b1;
            on_char  = 1'b1;
            #1;
            check($sformatf("%s_code%0d", tag, k), 32'(character_code), d[k]);
            check($sformatf("%s_sx%0d", tag, k), 32'(char_start_x), 64 + 16 * k);
            tick(1);
            check($sformatf("%s_pix%0d", tag, k), 32'(pixel_on), p[k]);
        end
        video_on = 1'b0;
        on_char  = 1'b0;
    endtask

    initial begin
        bit exp_in;
        bit prev_exp;
        int eidx;

        // Reset state
        #20;
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(value_ready), 1);
        check("rst_pix", 32'(pixel_on), 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Reset in the middle of a conversion aborts it
        send(1234);
        check("cv_busy", 32'(busy), 1);
        tick(5);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(value_ready), 1);
        check_tiles("abort", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(1);

        // 1234: frame_start inside CONVERT ignored, commit on the later pulse
        send(1234);
        check("t2_busy", 32'(busy), 1);
        check("t2_ready", 32'(value_ready), 0);
        tick(4);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(14);
        check("t2_hold_busy", 32'(busy), 1);
        x = 10'd66; y = 10'd40; #1;
        check("t2_nocommit", 32'(character_code), 0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("t2_idle_busy", 32'(busy), 0);
        check("t2_idle_ready", 32'(value_ready), 1);
        check_tiles("d1234", 1, 2, 3, 4, 1, 1, 1, 1);

        // Horizontal sweep over the tile row
        y = 10'd40;
        video_on = 1'b1;
        for (int xi = 60; xi <= 130; xi++) begin
            x       = 10'(xi);
            on_char = ((xi % 3) != 0);
            #1;
            exp_in = (xi >= 64) && (xi < 128);
            eidx   = exp_in ? (xi - 64) / 16 : 0;
            check($sformatf("sw_code_x%0d", xi), 32'(character_code), exp_in ? eidx + 1 : 0);
            check($sformatf("sw_sx_x%0d", xi), 32'(char_start_x), 64 + 16 * eidx);
            check($sformatf("sw_sy_x%0d", xi), 32'(char_start_y), 32);
            prev_exp = exp_in && on_char;
            tick(1);
            check($sformatf("sw_pix_x%0d", xi), 32'(pixel_on), 32'(prev_exp));
        end

        // Vertical edges of the row and video_on gating
        on_char = 1'b1;
        x = 10'd70;
        y = 10'd31; #1; check("y31_code", 32'(character_code), 0); tick(1); check("y31_pix", 32'(pixel_on), 0);
        y = 10'd32; #1; check("y32_code", 32'(character_code), 1); tick(1); check("y32_pix", 32'(pixel_on), 1);
        y = 10'd63; #1; check("y63_code", 32'(character_code), 1); tick(1); check("y63_pix", 32'(pixel_on), 1);
        y = 10'd64; #1; check("y64_code", 32'(character_code), 0); tick(1); check("y64_pix", 32'(pixel_on), 0);
        y = 10'd40; video_on = 1'b0;
        tick(1); check("vid_off_pix", 32'(pixel_on), 0);
        on_char = 1'b0;

        // 12000 saturates; latency exactly 14 clk with frame_start held high
        send(12000);
        frame_start = 1'b1;
        tick(14);
        check("t3_busy14", 32'(busy), 1);
        x = 10'd66; y = 10'd40; #1;
        check("t3_nocommit", 32'(character_code), 1);
        tick(1);
        frame_start = 1'b0;
        check("t3_busy15", 32'(busy), 0);
        check_tiles("d12000", 9, 9, 9, 9, 1, 1, 1, 1);

        // 42 then a second value (0) offered while busy
        send(42);
        value       = 14'd0;
        value_valid = 1'b1;
        tick(3);
        check("t6_ready_busy", 32'(value_ready), 0);
        check("t6_busy", 32'(busy), 1);
        tick(11);
        check("t6_ready_hold", 32'(value_ready), 0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("t6_commit_ready", 32'(value_ready), 1);
        check("t6_commit_busy", 32'(busy), 0);
        tick(1);
        check("t6_accept_busy", 32'(busy), 1);
        check("t6_accept_ready", 32'(value_ready), 0);
        value_valid = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        check_tiles("d42", 0, 0, 4, 2, 0, 0, 1, 1);
`else
        check_tiles("d42", 0, 0, 4, 2, 1, 1, 1, 1);
`endif
        frame_start = 1'b1;
        wait_idle();
        frame_start = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        check_tiles("d0", 0, 0, 0, 0, 0, 0, 0, 1);
`else
        check_tiles("d0", 0, 0, 0, 0, 1, 1, 1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
